// File: rtl/spi_master.sv
// spi_master -- single-clock SPI master, mode 0 (CPOL=0, CPHA=0), LSB first.
//
// A transfer of len+1 bits (1..DATA_W) is requested by pulsing start while
// idle. tx_data, len and ss_sel are latched on acceptance; the selected
// slaves are driven low for the whole transfer. SCK runs at clock/(2*DIV).
// MISO is sampled on the same clock edge that raises SCK, and MOSI only
// changes together with a falling SCK (or when a transfer starts), so it is
// always stable across rising edges.
//
// Frame timing for a start accepted at edge T:
//   LEAD  : DIV cycles, SCK low, first bit already on MOSI
//   HIGH  : DIV cycles per bit (MISO captured on entry)
//   LOW   : DIV cycles between bits (next MOSI bit set on entry)
//   TRAIL : DIV cycles after the last HIGH, SCK low, MOSI held
//   done pulses at T+1+DIV+2*DIV*(len+1), the cycle SS returns high.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   start    in   transfer request (ignored while busy)
//   len      in   transfer length minus one
//   tx_data  in   data to send, bit 0 first
//   ss_sel   in   slave-select mask, 1 selects a slave
//   busy     out  transfer in progress
//   done     out  one-cycle completion pulse
//   rx_data  out  received data, bit 0 first; bits above len read 0
//   sck      out  serial clock, idles low
//   ss       out  active-low slave selects
//   mosi     out  serial data out, idles high
//   miso     in   serial data in

module spi_master #(
    parameter int DIV    = 2,
    parameter int DATA_W = 32,
    parameter int NSS    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [$clog2(DATA_W)-1:0] len,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic [NSS-1:0]            ss_sel,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      sck,
    output logic [NSS-1:0]            ss,
    output logic                      mosi,
    input  logic                      miso
);

    localparam int LW = $clog2(DATA_W);
    // Phase counter only has to reach DIV-1; keep at least one bit.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL
    } state_t;

    state_t              state, state_d;
    logic [CW-1:0]       div_cnt, div_d;
    logic [LW-1:0]       bit_cnt, bit_d;
    logic [LW-1:0]       len_q, len_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_d;
    logic                sck_d;
    logic [NSS-1:0]      ss_d;
    logic                mosi_d;
    logic                busy_d;
    logic                done_d;

    logic                phase_end;
    logic [LW-1:0]       bit_nxt;

    assign phase_end = (div_cnt == CW'(DIV - 1));
    assign bit_nxt   = bit_cnt + LW'(1);

    // ------------------------------------------------------------------
    // State and output registers. All outputs are registered so that SCK,
    // SS and MOSI come straight from flops.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            len_q   <= '0;
            tx_q    <= '0;
            rx_data <= '0;
            sck     <= 1'b0;
            ss      <= '1;
            mosi    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            div_cnt <= div_d;
            bit_cnt <= bit_d;
            len_q   <= len_d;
            tx_q    <= tx_d;
            rx_data <= rx_d;
            sck     <= sck_d;
            ss      <= ss_d;
            mosi    <= mosi_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        div_d   = div_cnt + CW'(1);
        bit_d   = bit_cnt;
        len_d   = len_q;
        tx_d    = tx_q;
        rx_d    = rx_data;
        sck_d   = sck;
        ss_d    = ss;
        mosi_d  = mosi;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state)
            IDLE: begin
                div_d = '0;
                // done is high during this IDLE cycle when a frame just
                // ended, so a start here chains frames back to back.
                if (start) begin
                    tx_d    = tx_data;
                    len_d   = len;
                    rx_d    = '0;
                    bit_d   = '0;
                    ss_d    = ~ss_sel;
                    mosi_d  = tx_data[0];
                    sck_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = LEAD;
                end
            end

            LEAD: begin
                if (phase_end) begin
                    div_d         = '0;
                    sck_d         = 1'b1;
                    rx_d[bit_cnt] = miso;
                    state_d       = HIGH;
                end
            end

            HIGH: begin
                if (phase_end) begin
                    div_d = '0;
                    sck_d = 1'b0;
                    if (bit_cnt < len_q) begin
                        bit_d   = bit_nxt;
                        mosi_d  = tx_q[bit_nxt];
                        state_d = LOW;
                    end else begin
                        state_d = TRAIL;
                    end
                end
            end

            LOW: begin
                if (phase_end) begin
                    div_d         = '0;
                    sck_d         = 1'b1;
                    rx_d[bit_cnt] = miso;
                    state_d       = HIGH;
                end
            end

            TRAIL: begin
                if (phase_end) begin
                    div_d   = '0;
                    bit_d   = '0;
                    ss_d    = '1;
                    mosi_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                div_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (DIV=2, DATA_W=32, NSS=8).
// Inputs are driven and outputs sampled on the falling clock edge; cycle
// k=1 is the first cycle after the edge that accepted start.
module tb_spi_master;

    localparam int DIV = 2;

    logic        clock;
    logic        reset;
    logic        start;
    logic [4:0]  len;
    logic [31:0] tx_data;
    logic [7:0]  ss_sel;
    logic        busy;
    logic        done;
    logic [31:0] rx_data;
    logic        sck;
    logic [7:0]  ss;
    logic        mosi;
    logic        miso;

    int n_chk = 0;
    int n_err = 0;

    // 0: loopback, 1: constant miso_c, 2: bit-reversing slave
    int   mode = 0;
    logic miso_c = 1'b0;
    logic sl_miso;

    assign miso = (mode == 0) ? mosi : (mode == 1) ? miso_c : sl_miso;

    spi_master #(.DIV(DIV), .DATA_W(32), .NSS(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .len     (len),
        .tx_data (tx_data),
        .ss_sel  (ss_sel),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sck     (sck),
        .ss      (ss),
        .mosi    (mosi),
        .miso    (miso)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Mode-0 slave on ss[0]: receives the first byte, then returns it
    // bit-reversed, LSB first, changing miso after each falling sck.
    logic       sck_q = 1'b0;
    logic [7:0] rbyte = 8'h00;
    int         scnt  = 0;
    initial sl_miso = 1'b0;
    always @(posedge clock) begin
        sck_q <= sck;
        if (ss[0]) begin
            scnt    <= 0;
            sl_miso <= 1'b0;
        end else begin
            if (sck && !sck_q) begin
                if (scnt < 8) rbyte[scnt] <= mosi;
                scnt <= scnt + 1;
            end
            if (!sck && sck_q && scnt >= 8 && scnt < 16)
                sl_miso <= rbyte[7 - (scnt - 8)];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transfer; returns timing and waveform statistics. restart_at > 0
    // pulses start (with different data) at that cycle while busy.
    task automatic xfer(input logic [4:0] l, input logic [31:0] tx, input logic [7:0] sel,
                        input int restart_at,
                        output int done_at, output int ss_low, output int rises,
                        output int bad_period, output int glitch,
                        output logic [7:0] ss1, output logic mosi1, output logic busy1);
        logic prev_sck, prev_mosi;
        int   last_rise;
        done_at = -1; ss_low = 0; rises = 0; bad_period = 0; glitch = 0;
        ss1 = 8'h00; mosi1 = 1'b0; busy1 = 1'b0;
        prev_sck = 1'b0; prev_mosi = 1'b1; last_rise = -1;
        @(negedge clock);
        start = 1'b1; len = l; tx_data = tx; ss_sel = sel;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (k == 1) begin ss1 = ss; mosi1 = mosi; busy1 = busy; end
            if (k == restart_at) begin
                start = 1'b1; tx_data = ~tx; len = 5'd3; ss_sel = 8'hFF;
            end else begin
                start = 1'b0;
            end
            if (done) begin done_at = k; break; end
            if (ss != 8'hFF) ss_low++;
            if (sck && !prev_sck) begin
                rises++;
                if (last_rise >= 0 && (k - last_rise) != 2 * DIV) bad_period++;
                last_rise = k;
            end
            if (busy && k > 1 && mosi != prev_mosi && !(!sck && prev_sck)) glitch++;
            prev_sck = sck; prev_mosi = mosi;
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    int d_at, s_low, nr, badp, gl;
    logic [7:0] s1;
    logic m1, b1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; tx_data = '0; ss_sel = '0;
        repeat (3) @(negedge clock);

        // Reset state (start held high too: reset wins)
        start = 1'b1;
        @(negedge clock);
        check("rst_sck",  64'(sck), 64'(0));
        check("rst_ss",   64'(ss), 64'hFF);
        check("rst_mosi", 64'(mosi), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_rx",   64'(rx_data), 64'(0));
        start = 1'b0; reset = 1'b0;
        @(negedge clock);

        // 8-bit loopback
        mode = 0;
        xfer(5'd7, 32'h0000_00A5, 8'h01, 0, d_at, s_low, nr, badp, gl, s1, m1, b1);
        check("a5_done_at", 64'(d_at), 64'(35));
        check("a5_ss_low",  64'(s_low), 64'(34));
        check("a5_rises",   64'(nr), 64'(8));
        check("a5_period",  64'(badp), 64'(0));
        check("a5_mosi",    64'(gl), 64'(0));
        check("a5_ss1",     64'(s1), 64'hFE);
        check("a5_mosi1",   64'(m1), 64'(1));
        check("a5_busy1",   64'(b1), 64'(1));
        check("a5_rx",      64'(rx_data), 64'h0000_00A5);
        @(negedge clock);
        check("a5_done_pulse", 64'(done), 64'(0));
        check("a5_rx_hold",    64'(rx_data), 64'h0000_00A5);

        // 1-bit transfer, miso low
        mode = 1; miso_c = 1'b0;
        xfer(5'd0, 32'h0000_0001, 8'h01, 0, d_at, s_low, nr, badp, gl, s1, m1, b1);
        check("b1_done_at", 64'(d_at), 64'(1 + 3 * DIV));
        check("b1_rises",   64'(nr), 64'(1));
        check("b1_ss_low",  64'(s_low), 64'(3 * DIV));
        check("b1_mosi1",   64'(m1), 64'(1));
        check("b1_rx",      64'(rx_data), 64'(0));

        // 32-bit loopback with an ignored start mid-transfer
        mode = 0;
        xfer(5'd31, 32'hDEAD_BEEF, 8'h01, 40, d_at, s_low, nr, badp, gl, s1, m1, b1);
        check("w_done_at", 64'(d_at), 64'(131));
        check("w_rises",   64'(nr), 64'(32));
        check("w_ss_low",  64'(s_low), 64'(130));
        check("w_period",  64'(badp), 64'(0));
        check("w_mosi",    64'(gl), 64'(0));
        check("w_rx",      64'(rx_data), 64'hDEAD_BEEF);
        begin
            int extra = 0;
            int bz = 0;
            for (int k = 0; k < 150; k++) begin
                @(negedge clock);
                if (done) extra++;
                if (busy) bz++;
            end
            check("w_extra_done", 64'(extra), 64'(0));
            check("w_extra_busy", 64'(bz), 64'(0));
        end

        // No slave selected: same timing, ss stays high
        xfer(5'd3, 32'h0000_0009, 8'h00, 0, d_at, s_low, nr, badp, gl, s1, m1, b1);
        check("z_done_at", 64'(d_at), 64'(19));
        check("z_ss_low",  64'(s_low), 64'(0));
        check("z_ss1",     64'(s1), 64'hFF);
        check("z_rises",   64'(nr), 64'(4));
        check("z_rx",      64'(rx_data), 64'h9);

        // Reset after the 5th rising sck edge
        begin
            int   rr = 0;
            int   nd = 0;
            logic ps = 1'b0;
            @(negedge clock);
            start = 1'b1; len = 5'd7; tx_data = 32'hFF; ss_sel = 8'h80;
            @(negedge clock);
            start = 1'b0;
            for (int k = 0; k < 100; k++) begin
                if (sck && !ps) rr++;
                if (rr == 5) break;
                ps = sck;
                @(negedge clock);
            end
            check("r_rises", 64'(rr), 64'(5));
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            check("r_ss",   64'(ss), 64'hFF);
            check("r_sck",  64'(sck), 64'(0));
            check("r_busy", 64'(busy), 64'(0));
            check("r_done", 64'(done), 64'(0));
            check("r_mosi", 64'(mosi), 64'(1));
            for (int k = 0; k < 60; k++) begin
                @(negedge clock);
                if (done) nd++;
            end
            check("r_no_done", 64'(nd), 64'(0));
        end
        xfer(5'd7, 32'h0000_003C, 8'h80, 0, d_at, s_low, nr, badp, gl, s1, m1, b1);
        check("r2_done_at", 64'(d_at), 64'(35));
        check("r2_ss1",     64'(s1), 64'h7F);
        check("r2_rx",      64'(rx_data), 64'h3C);

        // start held high: back-to-back frames
        begin
            int nd = 0;
            int d1 = 0, d2 = 0, d3 = 0;
            logic [7:0] s20 = 8'h00, s39 = 8'h00, s58 = 8'h00;
            @(negedge clock);
            start = 1'b1; len = 5'd3; tx_data = 32'h5; ss_sel = 8'h02;
            for (int k = 1; k <= 70; k++) begin
                @(negedge clock);
                if (done) begin
                    nd++;
                    if (nd == 1) d1 = k; else if (nd == 2) d2 = k; else if (nd == 3) d3 = k;
                end
                if (k == 20) s20 = ss;
                if (k == 39) begin s39 = ss; start = 1'b0; end
                if (k == 58) s58 = ss;
            end
            check("h_ndone", 64'(nd), 64'(3));
            check("h_d1",    64'(d1), 64'(19));
            check("h_d2",    64'(d2), 64'(38));
            check("h_d3",    64'(d3), 64'(57));
            check("h_ss20",  64'(s20), 64'hFD);
            check("h_ss39",  64'(s39), 64'hFD);
            check("h_ss58",  64'(s58), 64'hFF);
            check("h_rx",    64'(rx_data), 64'h5);
        end

        // Bit-reversing slave, 16-bit frames
        mode = 2;
        xfer(5'd15, 32'h0000_FF01, 8'h01, 0, d_at, s_low, nr, badp, gl, s1, m1, b1);
        check("s1_done_at", 64'(d_at), 64'(67));
        check("s1_rises",   64'(nr), 64'(16));
        check("s1_period",  64'(badp), 64'(0));
        check("s1_rx",      64'(rx_data), 64'h0000_8000);
        @(negedge clock);
        xfer(5'd15, 32'h0000_0035, 8'h01, 0, d_at, s_low, nr, badp, gl, s1, m1, b1);
        check("s2_period",  64'(badp), 64'(0));
        check("s2_mosi",    64'(gl), 64'(0));
        check("s2_rx",      64'(rx_data), 64'h0000_AC00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DIV, default 2: SCK half-period in clock cycles; legal values are 1 or more.
REQ-002 SHALL have parameter DATA_W, default 32: maximum transfer length in bits.
REQ-003 SHALL have parameter NSS, default 8: number of slave-select lines.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: transfer request, sampled each cycle.
REQ-007 SHALL have port len, input, $clog2(DATA_W) bits: transfer length minus 1 (0 means 1 bit).
REQ-008 SHALL have port tx_data, input, DATA_W bits: data to shift out, LSB first.
REQ-009 SHALL have port ss_sel, input, NSS bits: slave-select mask; 1 selects that slave.
REQ-010 SHALL have port busy, output, 1 bit: a transfer is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a transfer completes.
REQ-012 SHALL have port rx_data, output, DATA_W bits: received data, LSB first, held until the next start.
REQ-013 SHALL have port sck, output, 1 bit: serial clock; idles low (CPOL=0, CPHA=0).
REQ-014 SHALL have port ss, output, NSS bits: active-low slave selects.
REQ-015 SHALL have port mosi, output, 1 bit: serial data out; idles 1.
REQ-016 SHALL have port miso, input, 1 bit: serial data in.

Function
REQ-017 SHALL implement the states IDLE, LEAD, HIGH, LOW and TRAIL.
REQ-018 In IDLE: sck=0, ss all 1s, mosi=1, busy=0.
REQ-019 If start=1 in IDLE at cycle T: SHALL latch tx_data, len and ss_sel, clear rx_data to 0 and enter LEAD.
REQ-020 At cycle T+1: ss=~ss_sel_latched, mosi=tx bit 0, busy=1.
REQ-021 LEAD SHALL last DIV cycles with sck=0, then enter HIGH: sck=1, and the miso value is captured into rx_data[bit_cnt] on that same edge.
REQ-022 HIGH SHALL last DIV cycles. On exit, sck=0, and:
- if bit_cnt < len: increment bit_cnt, set mosi = tx bit bit_cnt+1, and enter LOW;
- otherwise enter TRAIL.
REQ-023 LOW SHALL last DIV cycles, then enter HIGH: sck=1, and miso is captured into the next rx bit.
REQ-024 TRAIL SHALL last DIV cycles with sck=0 and mosi held.
- On TRAIL exit: ss=all 1s, mosi=1, busy=0, done=1 for exactly one cycle, and the state returns to IDLE.
REQ-025 Timing: ss is low for DIV + 2*DIV*(len+1) cycles, and done asserts at cycle T+1+DIV+2*DIV*(len+1).
REQ-026 Every sck period SHALL be exactly 2*DIV cycles, with exactly len+1 rising edges per transfer.
REQ-027 start while busy=1 SHALL be ignored; no latching occurs and the transfer in flight is unaffected.
REQ-028 start in the same cycle that done=1 SHALL be accepted; the next transfer begins in the following cycle.
REQ-029 rx_data bits above len SHALL read 0; tx_data bits above len SHALL be ignored.
REQ-030 ss_sel=0 SHALL still run a full transfer (timing identical) with all ss lines high.
REQ-031 tx_data, len and ss_sel changes during busy=1 SHALL have no effect.
REQ-032 mosi SHALL change only on a cycle where sck falls, or at transfer start; it is stable across every sck rising edge.

Reset
REQ-033 reset=1 at a clock edge SHALL force, from the next cycle: state=IDLE, sck=0, ss all 1s, mosi=1, busy=0, done=0, rx_data=0, and all counters 0.
REQ-034 reset mid-transfer SHALL abort the transfer with no done pulse; ss deasserts the next cycle.
REQ-035 reset SHALL take priority over start in the same cycle.

Verification
REQ-036 Directed: DIV=2, len=7, tx=0xA5, ss_sel=0x01, miso tied to mosi -> rx_data=0x000000A5, done at T+35, ss[0] low for 34 cycles, 8 sck rising edges.
REQ-037 Directed: len=0, tx=1, miso=0 -> 1 sck pulse, rx_data=0, and done at T+1+3*DIV.
REQ-038 Directed: len=31, tx=0xDEADBEEF, loopback -> rx_data=0xDEADBEEF; a second start pulsed mid-transfer is ignored and yields exactly one done.
REQ-039 Directed: reset asserted at the 5th sck rising edge -> next cycle ss=0xFF, sck=0, busy=0, no done; a new start then completes normally.
REQ-040 Directed: start held high continuously -> back-to-back transfers, each done followed by ss low again in the next cycle.
REQ-041 Directed: connected to the bitrev slave, 16-bit transfer, tx low byte 0x01 -> rx_data[15:8] equals the bit-reversed first byte per the slave's TX timing, and all sck edges are 2*DIV apart.
